// File: rtl/uart_tx_sched_if.sv
// Signal bundle shared by the byte requesters, the baud generator/transmitter pair
// and the uart_tx_sched arbiter. The scheduler takes the slave side.
interface uart_tx_sched_if #(
  parameter int NREQ = 4
) ();
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [3*NREQ-1:0] req_sel;
  logic [NREQ-1:0]   req_ready;
  logic              baud_tick;
  logic [2:0]        brg_sel;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic [GW-1:0]     grant_id;
  logic              sched_busy;
  logic              err_timeout;

  modport master (
    output req_valid, req_data, req_sel, baud_tick, tx_done,
    input  req_ready, brg_sel, tx_start, tx_data, grant_id, sched_busy, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_sel, baud_tick, tx_done,
    output req_ready, brg_sel, tx_start, tx_data, grant_id, sched_busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin sharing of one UART transmitter and its baud generator among NREQ requesters,
// with baud reprogramming, settle delay, completion watchdog and inter-frame guard gap.
module uart_tx_sched #(
  parameter int NREQ          = 4,
  parameter int SETTLE_TICKS  = 16,
  parameter int GUARD_TICKS   = 2,
  parameter int TIMEOUT_TICKS = 200
) (
  input logic            sysclk,
  input logic            rst,
  uart_tx_sched_if.slave bus
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECONF,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GUARD
  } state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [7:0]    tick_cnt;
  logic [7:0]    tick_inc;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [2:0]    pick_sel;
  logic [GW-1:0] next_ptr;

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    // Walk backwards so the candidate closest to rr_ptr is written last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign pick_sel        = bus.req_sel[3*int'(pick_idx) +: 3];
  assign tick_inc        = (tick_cnt == 8'hFF) ? tick_cnt : tick_cnt + 8'd1;
  assign next_ptr        = (int'(bus.grant_id) == NREQ - 1) ? '0 : bus.grant_id + GW'(1);
  assign bus.sched_busy  = (state != S_IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      tick_cnt        <= '0;
      bus.req_ready   <= '0;
      bus.brg_sel     <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.grant_id    <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.req_ready   <= '0;
      bus.tx_start    <= 1'b0;
      bus.err_timeout <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (pick_found) begin
            bus.grant_id <= pick_idx;
            if (pick_sel == bus.brg_sel) begin
              state <= S_LAUNCH;
            end else begin
              bus.brg_sel <= pick_sel;
              tick_cnt    <= '0;
              state       <= S_RECONF;
            end
          end
        end

        S_RECONF: begin
          if (bus.baud_tick) begin
            tick_cnt <= tick_inc;
            if (tick_inc == 8'(SETTLE_TICKS)) state <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          // A requester that withdrew while we were settling forfeits its turn.
          if (bus.req_valid[bus.grant_id]) begin
            bus.req_ready <= NREQ'(1) << bus.grant_id;
            bus.tx_start  <= 1'b1;
            bus.tx_data   <= bus.req_data[8*int'(bus.grant_id) +: 8];
            tick_cnt      <= '0;
            rr_ptr        <= next_ptr;
            state         <= S_WAIT_DONE;
          end else begin
            state <= S_IDLE;
          end
        end

        S_WAIT_DONE: begin
          if (bus.tx_done) begin
            tick_cnt <= '0;
            state    <= S_GUARD;
          end else if (bus.baud_tick) begin
            if (tick_inc == 8'(TIMEOUT_TICKS)) begin
              bus.err_timeout <= 1'b1;
              tick_cnt        <= '0;
              state           <= S_GUARD;
            end else begin
              tick_cnt <= tick_inc;
            end
          end
        end

        S_GUARD: begin
          if (GUARD_TICKS == 0) begin
            state <= S_IDLE;
          end else if (bus.baud_tick) begin
            tick_cnt <= tick_inc;
            if (tick_inc == 8'(GUARD_TICKS)) state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester, baud and transmitter models run
// cycle by cycle on the falling edge; expected launches are queued at stimulus time.
module tb_uart_tx_sched;
  localparam int NREQ     = 4;
  localparam int SETTLE   = 16;
  localparam int GUARD    = 2;
  localparam int TIMEOUT  = 200;
  localparam int BAUD_DIV = 3;
  localparam int FRAME    = 10;

  logic sysclk = 1'b0;
  logic rst    = 1'b0;

  uart_tx_sched_if #(.NREQ(NREQ)) bus ();

  uart_tx_sched #(
    .NREQ(NREQ), .SETTLE_TICKS(SETTLE), .GUARD_TICKS(GUARD), .TIMEOUT_TICKS(TIMEOUT)
  ) dut (
    .sysclk(sysclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [2:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  int         div_cnt = 0;
  bit         tx_busy = 0, tx_mute = 0;
  int         frame_cnt = 0;
  logic [7:0] last_data = '0;
  bit         wd_on = 0;     int wd_cnt = 0;     int exp_err_cyc = -1;
  bit         gap_on = 0;    int gap_cnt = 0;    int exp_gap_cyc = -1;  bit chk_gap = 0;
  bit         settle_on = 0; int settle_cnt = 0; int exp_set_cyc = -1;  bit chk_settle = 0;
  logic [2:0]      prev_brg   = '0;
  logic [NREQ-1:0] prev_ready = '0;
  int         rq_left[NREQ];
  logic [7:0] rq_data[NREQ];
  int         ready_cnt[NREQ];
  int         launches = 0, err_cnt = 0, brg_change_cyc = -1;
  int         start_log[$];
  int         n, mark, post_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One sysclk cycle: sample this cycle's outputs, update models, then drive this cycle's inputs.
  task automatic step();
    exp_t            e;
    logic [NREQ-1:0] one;
    @(negedge sysclk);
    cyc++;
    if (bus.brg_sel !== prev_brg) begin
      brg_change_cyc = cyc;
      settle_on      = 1;
      settle_cnt     = 0;
    end
    prev_brg = bus.brg_sel;

    if (bus.req_ready !== '0) begin
      check("ready_width", bus.req_ready & prev_ready, 0);
      if (!bus.tx_start) check("ready_without_start", bus.req_ready, 0);
    end
    prev_ready = bus.req_ready;

    if (bus.tx_start) begin
      launches++;
      start_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_start", bus.tx_start, 0);
      end else begin
        e   = exp_q.pop_front();
        one = NREQ'(1) << e.id;
        check("grant_id", bus.grant_id, e.id);
        check("tx_data", bus.tx_data, e.data);
        check("brg_sel_at_start", bus.brg_sel, e.sel);
        check("ready_onehot", bus.req_ready, one);
      end
      if (chk_settle && exp_set_cyc >= 0) begin
        check("settle_launch_cycle", cyc, exp_set_cyc);
        exp_set_cyc = -1;
      end
      if (chk_gap && exp_gap_cyc >= 0) begin
        check("guard_gap_cycle", cyc, exp_gap_cyc);
        exp_gap_cyc = -1;
      end
      tx_busy = 1; frame_cnt = 0; last_data = bus.tx_data;
      wd_on   = 1; wd_cnt    = 0;
    end

    if (bus.err_timeout) err_cnt++;
    if (bus.err_timeout || cyc == exp_err_cyc)
      check("err_timeout", bus.err_timeout, cyc == exp_err_cyc);

    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        ready_cnt[i]++;
        rq_left[i]--;
        if (rq_left[i] > 0) begin
          rq_data[i]++;
          bus.req_data[8*i +: 8] = rq_data[i];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end

    bus.tx_done   = 1'b0;
    bus.baud_tick = 1'b0;
    div_cnt++;
    if (div_cnt == BAUD_DIV) begin
      div_cnt       = 0;
      bus.baud_tick = 1'b1;
    end
    if (bus.baud_tick) begin
      // Launch follows the settling tick by two cycles: one LAUNCH cycle, then the registered pulse.
      if (settle_on) begin
        settle_cnt++;
        if (settle_cnt == SETTLE) begin exp_set_cyc = cyc + 2; settle_on = 0; end
      end
      // Last guard tick, then IDLE, LAUNCH, registered pulse.
      if (gap_on) begin
        gap_cnt++;
        if (gap_cnt == GUARD) begin exp_gap_cyc = cyc + 3; gap_on = 0; end
      end
      if (tx_busy && !tx_mute) begin
        frame_cnt++;
        if (frame_cnt == FRAME) begin bus.tx_done = 1'b1; tx_busy = 0; wd_on = 0; end
      end
      if (wd_on) begin
        wd_cnt++;
        if (wd_cnt == TIMEOUT) begin exp_err_cyc = cyc + 1; wd_on = 0; tx_busy = 0; end
      end
    end
    if (bus.tx_done) begin
      check("tx_data_hold", bus.tx_data, last_data);
      gap_on  = 1;
      gap_cnt = 0;
    end
  endtask

  task automatic post(input int i, input logic [2:0] sel, input logic [7:0] d, input int cnt);
    rq_left[i]             = cnt;
    rq_data[i]             = d;
    bus.req_data[8*i +: 8] = d;
    bus.req_sel[3*i +: 3]  = sel;
    bus.req_valid[i]       = 1'b1;
  endtask

  task automatic expect_grant(input int i, input logic [7:0] d, input logic [2:0] sel);
    exp_t e;
    e.id = i; e.data = d; e.sel = sel;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    do begin
      step();
      k++;
    end while ((exp_q.size() != 0 || bus.sched_busy || bus.req_valid != '0) && k < budget);
    check(tag, k < budget, 1);
  endtask

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_sel = '0;
    bus.baud_tick = 1'b0; bus.tx_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rq_left[i] = 0; rq_data[i] = '0; ready_cnt[i] = 0; end

    rst = 1'b0;
    step(); step();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_brg_sel", bus.brg_sel, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_busy", bus.sched_busy, 0);
    check("rst_err", bus.err_timeout, 0);
    rst = 1'b1;

    // Requesters 0 and 2 on the current baud: no reconfiguration, guard gap between them.
    start_log.delete(); chk_gap = 1; exp_gap_cyc = -1;
    post(0, 3'd0, 8'hA0, 1); post(2, 3'd0, 8'hA2, 1);
    expect_grant(0, 8'hA0, 3'd0); expect_grant(2, 8'hA2, 3'd0);
    post_cyc = cyc;
    drain("t1_drain", 400);
    check("t1_launches", start_log.size(), 2);
    check("t1_first_latency", start_log[0], post_cyc + 2);
    chk_gap = 0;

    // Pointer is now 3: with 1 and 3 pending, 3 must go first.
    post(1, 3'd0, 8'hB1, 1); post(3, 3'd0, 8'hB3, 1);
    expect_grant(3, 8'hB3, 3'd0); expect_grant(1, 8'hB1, 3'd0);
    drain("ptr_drain", 400);

    // Requester 1 needs sel=5: reprogram, settle 16 ticks, launch once.
    chk_settle = 1; exp_set_cyc = -1; mark = ready_cnt[1];
    post(1, 3'd5, 8'h51, 1); expect_grant(1, 8'h51, 3'd5);
    post_cyc = cyc;
    drain("t2_drain", 400);
    check("t2_brg_change_cycle", brg_change_cyc, post_cyc + 1);
    check("t2_brg_sel", bus.brg_sel, 5);
    check("t2_ready_once", ready_cnt[1] - mark, 1);
    chk_settle = 0;

    // Requester 3 withdraws during RECONF: no launch, new brg_sel kept, pointer stays at 2.
    mark = launches;
    post(3, 3'd2, 8'hE3, 1);
    n = 0;
    while (bus.brg_sel !== 3'd2 && n < 20) begin step(); n++; end
    check("t5_reconf_entered", bus.brg_sel, 2);
    step(); step();
    bus.req_valid[3] = 1'b0; rq_left[3] = 0;
    drain("t5_drain", 400);
    check("t5_no_launch", launches - mark, 0);
    check("t5_brg_kept", bus.brg_sel, 2);
    post(1, 3'd2, 8'hF1, 1); post(2, 3'd2, 8'hF2, 1);
    expect_grant(2, 8'hF2, 3'd2); expect_grant(1, 8'hF1, 3'd2);
    drain("t5_ptr_drain", 400);

    // Transmitter never completes: watchdog fires, then service resumes.
    tx_mute = 1; mark = err_cnt;
    post(0, 3'd2, 8'hC0, 1); expect_grant(0, 8'hC0, 3'd2);
    drain("t4_drain", 1200);
    check("t4_err_once", err_cnt - mark, 1);
    tx_mute = 0;
    post(1, 3'd2, 8'hC1, 1); expect_grant(1, 8'hC1, 3'd2);
    drain("t4_resume_drain", 400);

    // Reset in the middle of WAIT_DONE.
    tx_mute = 1; mark = launches;
    post(2, 3'd2, 8'hD2, 1); expect_grant(2, 8'hD2, 3'd2);
    n = 0;
    while (launches == mark && n < 20) begin step(); n++; end
    check("t6_launched", launches - mark, 1);
    repeat (5) step();
    tx_busy = 0; wd_on = 0; exp_err_cyc = -1; gap_on = 0; tx_mute = 0;
    rst = 1'b0;
    step();
    check("t6_req_ready", bus.req_ready, 0);
    check("t6_brg_sel", bus.brg_sel, 0);
    check("t6_tx_start", bus.tx_start, 0);
    check("t6_tx_data", bus.tx_data, 0);
    check("t6_grant_id", bus.grant_id, 0);
    check("t6_busy", bus.sched_busy, 0);
    check("t6_err", bus.err_timeout, 0);
    rst = 1'b1;
    post(1, 3'd0, 8'h61, 1); post(3, 3'd0, 8'h63, 1);
    expect_grant(1, 8'h61, 3'd0); expect_grant(3, 8'h63, 3'd0);
    drain("t6_drain", 400);

    // All four continuously valid for two rounds, pointer starting at 0.
    for (int i = 0; i < NREQ; i++) post(i, 3'd0, 8'h10 * (i + 1), 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) expect_grant(i, 8'((8'h10 * (i + 1)) + r), 3'd0);
    mark = launches;
    drain("t3_drain", 1200);
    check("t3_launches", launches - mark, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_time_limit: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter and its baud rate generator among NREQ byte requesters.
- Each requester supplies a byte and its own baud select code.
- Per grant, the block reprograms the generator's select input when the code differs from the current one, waits a settle interval counted in baud ticks, and launches the byte.
- It then waits for transmitter completion and enforces an inter-frame guard gap before the next grant.

Parameters:
NREQ, 4, number of requesters (2..8)
SETTLE_TICKS, 16, baud ticks to wait after changing brg_sel before launch (1..255)
GUARD_TICKS, 2, idle baud ticks after tx_done before next arbitration (0..255)
TIMEOUT_TICKS, 200, baud ticks allowed from launch to tx_done before abort (1..255)

Ports:
sysclk  in  1  system clock
rst  in  1  reset, synchronous, active-low
req_valid  in  NREQ  per-requester byte pending; held until req_ready
req_data  in  8*NREQ  byte for requester i in bits [8i+7:8i]
req_sel  in  3*NREQ  baud select for requester i in bits [3i+2:3i]
req_ready  out  NREQ  one-hot, one-cycle accept pulse
baud_tick  in  1  one-sysclk pulse per baud period, already synchronous to sysclk
brg_sel  out  3  select driven to baud rate generator
tx_start  out  1  one-cycle launch pulse to transmitter
tx_data  out  8  byte to transmitter, valid while tx_start and held until tx_done
tx_done  in  1  one-cycle pulse at end of stop bit
grant_id  out  clog2(NREQ)  index of current or last grantee
sched_busy  out  1  high in any state other than IDLE
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst=0 at sysclk edge):
  - Outputs: req_ready=0, brg_sel=0, tx_start=0, tx_data=0, grant_id=0, sched_busy=0, err_timeout=0.
  - Internal state: RR pointer=0, tick counter=0, state=IDLE.
  - Reset is honoured in every state and aborts any operation. No pulse output may be high in the cycle after reset.
- States: IDLE, RECONF, LAUNCH, WAIT_DONE, GUARD.
- IDLE:
  - If any req_valid is high, select the first valid index at or after the RR pointer, cyclically.
  - Register grant_id.
  - If req_sel[grant] equals brg_sel, go to LAUNCH. Otherwise load brg_sel=req_sel[grant], clear the tick counter, and go to RECONF.
  - Arbitration takes 1 cycle.
- RECONF:
  - Count baud_tick pulses.
  - When the count reaches SETTLE_TICKS, go to LAUNCH.
  - brg_sel stays stable for the whole state.
- LAUNCH (1 cycle):
  - If req_valid[grant_id] is still high: pulse req_ready[grant_id] and tx_start, latch tx_data=req_data[grant], clear the tick counter, advance the RR pointer to grant_id+1 mod NREQ, and go to WAIT_DONE.
  - If req_valid[grant_id] has dropped: no pulses, pointer unchanged, return to IDLE. brg_sel keeps its new value.
- WAIT_DONE:
  - tx_data held.
  - tx_done: clear the counter and go to GUARD.
  - Otherwise count baud ticks. At TIMEOUT_TICKS, pulse err_timeout and go to GUARD.
  - tx_done and a baud tick in the same cycle: tx_done wins and that tick is not counted.
- GUARD:
  - Count baud ticks. When the count reaches GUARD_TICKS, go to IDLE.
  - GUARD_TICKS=0: leave GUARD after exactly 1 cycle.
- Timing:
  - Minimum launch-to-launch spacing is the transmitter frame plus GUARD_TICKS ticks plus 2 sysclk cycles.
  - No new request is accepted before GUARD completes.
- Inputs:
  - tx_done outside WAIT_DONE is ignored.
  - Changes on req_sel or req_data after grant and before LAUNCH: data is sampled at LAUNCH. The sel change is not re-checked.
- Arithmetic:
  - Tick counter is 8 bits and saturating; the compare is ==.
  - RR pointer wraps at NREQ, not at a power of 2.
- Pulse timing: req_ready and tx_start pulse in the same cycle. Both are registered outputs, asserted the cycle after LAUNCH entry is decided.

Test Plan:
1. Requesters 0 and 2 valid, both sel=0, brg_sel=0 → byte0 launched without RECONF; after tx_done and 2 ticks, byte2 launched; grant_id sequence 0,2; RR pointer 3.
2. Requester 1 valid with sel=5 while brg_sel=0 → brg_sel=5 next cycle; tx_start exactly at the 16th baud_tick after the change; req_ready[1] pulses once.
3. All four valid continuously for 8 frames → grant order 0,1,2,3,0,1,2,3; each req_ready pulse is exactly 1 cycle wide.
4. tx_done never returned → err_timeout pulses at the 200th tick after tx_start; block returns to IDLE after the guard; the next grant proceeds.
5. req_valid[3] dropped during RECONF → no tx_start, no req_ready; brg_sel keeps the new value; state returns to IDLE; pointer unchanged.
6. rst=0 asserted mid WAIT_DONE → all outputs at reset values next cycle; a subsequent request is served normally from pointer 0.
